// File: rtl/controlador_mdio.sv
// MDIO management master: sequences one 32-bit frame per request and generates mdc.
// Reads release the line after 16 bits and capture the 16-bit reply.
module controlador_mdio #(
  parameter int PREAMBULO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [31:0] transaccion,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        ocupado,
  output logic        listo,
  output logic        error,
  output logic [15:0] dato_leido,
  output logic [3:0]  estado_dbg
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_PRE  = 4'b0010,
    S_ENV  = 4'b0100,
    S_REC  = 4'b1000
  } estado_t;

  localparam logic [5:0] PRE_ULT = (PREAMBULO > 0) ? 6'(PREAMBULO - 1) : 6'd0;

  estado_t     estado, estado_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [31:0] trama, trama_nxt;
  logic [14:0] shift, shift_nxt;
  logic        out_nxt, oe_nxt, ocupado_nxt, listo_nxt, error_nxt;
  logic [15:0] dato_nxt;
  logic [4:0]  idx_sig;
  logic        bajada;
  logic        op_valida;
  logic        es_lectura;

  // Every line update happens on the clk edge where mdc goes 1->0.
  assign bajada     = mdc;
  assign op_valida  = transaccion[29] ^ transaccion[28];
  assign es_lectura = trama[29];
  assign idx_sig    = 5'd30 - cnt[4:0];
  assign estado_dbg = estado;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= S_IDLE;
      cnt        <= '0;
      trama      <= '0;
      shift      <= '0;
      mdc        <= 1'b0;
      mdio_out   <= 1'b0;
      mdio_oe    <= 1'b0;
      ocupado    <= 1'b0;
      listo      <= 1'b0;
      error      <= 1'b0;
      dato_leido <= '0;
    end else begin
      estado     <= estado_nxt;
      cnt        <= cnt_nxt;
      trama      <= trama_nxt;
      shift      <= shift_nxt;
      mdc        <= ~mdc;
      mdio_out   <= out_nxt;
      mdio_oe    <= oe_nxt;
      ocupado    <= ocupado_nxt;
      listo      <= listo_nxt;
      error      <= error_nxt;
      dato_leido <= dato_nxt;
    end
  end

  // Request handshake: iniciar is taken only in IDLE with ocupado low; a valid
  // op latches the frame and raises ocupado, an invalid op pulses error instead.
  always_comb begin
    estado_nxt  = estado;
    cnt_nxt     = cnt;
    trama_nxt   = trama;
    shift_nxt   = shift;
    out_nxt     = mdio_out;
    oe_nxt      = mdio_oe;
    ocupado_nxt = ocupado;
    listo_nxt   = 1'b0;
    error_nxt   = 1'b0;
    dato_nxt    = dato_leido;
    unique case (estado)
      S_IDLE: begin
        if (!ocupado) begin
          if (iniciar) begin
            if (op_valida) begin
              trama_nxt   = transaccion;
              ocupado_nxt = 1'b1;
            end else begin
              error_nxt = 1'b1;
            end
          end
        end else if (bajada) begin
          cnt_nxt = '0;
          oe_nxt  = 1'b1;
          if (PREAMBULO > 0) begin
            estado_nxt = S_PRE;
            out_nxt    = 1'b1;
          end else begin
            estado_nxt = S_ENV;
            out_nxt    = trama[31];
          end
        end
      end
      S_PRE: begin
        if (bajada) begin
          if (cnt == PRE_ULT) begin
            estado_nxt = S_ENV;
            cnt_nxt    = '0;
            out_nxt    = trama[31];
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end
      S_ENV: begin
        if (bajada) begin
          // Reads stop after TA (bit 16), writes after bit 0.
          if ((es_lectura && cnt == 6'd15) || cnt == 6'd31) begin
            oe_nxt  = 1'b0;
            out_nxt = 1'b0;
            cnt_nxt = '0;
            if (es_lectura) begin
              estado_nxt = S_REC;
            end else begin
              estado_nxt  = S_IDLE;
              ocupado_nxt = 1'b0;
              listo_nxt   = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 6'd1;
            out_nxt = trama[idx_sig];
          end
        end
      end
      S_REC: begin
        if (bajada) begin
          shift_nxt = {shift[13:0], mdio_in};
          if (cnt == 6'd15) begin
            dato_nxt    = {shift, mdio_in};
            estado_nxt  = S_IDLE;
            ocupado_nxt = 1'b0;
            listo_nxt   = 1'b1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end
      default: begin
        estado_nxt  = S_IDLE;
        cnt_nxt     = '0;
        oe_nxt      = 1'b0;
        out_nxt     = 1'b0;
        ocupado_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_controlador_mdio.sv
// Bench for controlador_mdio: table vectors, randomized frames, preamble and reset cases,
// with a small MDIO target model answering reads.
module tb_controlador_mdio;

  logic        clk;
  logic        reset;
  logic        iniciar;
  logic [31:0] transaccion;
  logic        mdio_in;
  logic        mdc, mdio_out, mdio_oe, ocupado, listo, error;
  logic [15:0] dato_leido;
  logic [3:0]  estado_dbg;

  logic        iniciar_p;
  logic [31:0] trans_p;
  logic        mdio_in_p;
  logic        mdc_p, out_p, oe_p, ocu_p, listo_p, err_p;
  logic [15:0] dato_p;
  logic [3:0]  dbg_p;

  controlador_mdio #(.PREAMBULO(0)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .transaccion(transaccion),
    .mdio_in(mdio_in), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
    .ocupado(ocupado), .listo(listo), .error(error), .dato_leido(dato_leido),
    .estado_dbg(estado_dbg)
  );

  controlador_mdio #(.PREAMBULO(32)) dut_pre (
    .clk(clk), .reset(reset), .iniciar(iniciar_p), .transaccion(trans_p),
    .mdio_in(mdio_in_p), .mdc(mdc_p), .mdio_out(out_p), .mdio_oe(oe_p),
    .ocupado(ocu_p), .listo(listo_p), .error(err_p), .dato_leido(dato_p),
    .estado_dbg(dbg_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_dato;

  // Target model: captures driven bits on rising mdc, answers reads after TA.
  logic [15:0] tgt_reply;
  logic [31:0] tgt_bits;
  int          tgt_cnt;
  int          rep_idx;
  logic        prev_oe = 1'b0;

  always @(posedge mdc) begin
    if (mdio_oe) begin
      if (!prev_oe) begin
        tgt_bits = {31'b0, mdio_out};
        tgt_cnt  = 1;
        rep_idx  = 0;
        mdio_in  = 1'b0;
      end else begin
        tgt_bits = {tgt_bits[30:0], mdio_out};
        tgt_cnt  = tgt_cnt + 1;
      end
    end else if (tgt_cnt == 16 && tgt_bits[13:12] == 2'b10 && rep_idx < 16) begin
      #1 mdio_in = tgt_reply[15 - rep_idx];
      rep_idx = rep_idx + 1;
    end
    prev_oe = mdio_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  task automatic run_txn(input logic [31:0] fr, input logic [15:0] rep, input bit mid,
                         input bit exp_err, input logic [15:0] exp_dato, input int abort_at);
    logic [1:0] stream [64];
    bit rd;
    int w;
    rd = (fr[29:28] == 2'b10);
    for (int i = 0; i < 64; i++)
      stream[i] = (rd && i >= 32) ? 2'b00 : {1'b1, fr[31 - i / 2]};
    tgt_reply = rep;
    @(negedge clk);
    transaccion = fr;
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    transaccion = $urandom;
    if (exp_err) begin
      check("error_pulso", 32'({ocupado, mdio_oe, error}), 32'b001);
      @(negedge clk);
      check("error_ancho", 32'({ocupado, mdio_oe, error}), 32'b000);
      check("error_dato", 32'(dato_leido), 32'(exp_dato));
      return;
    end
    check("aceptar", 32'({ocupado, error}), 32'b10);
    exp_q.push_back(exp_dato);
    w = 0;
    while (!mdio_oe && w < 4) begin
      @(negedge clk);
      w++;
    end
    check("latencia", 32'(w >= 1 && w <= 2), 32'd1);
    for (int k = 0; k < 64; k++) begin
      check("linea", 32'({listo, ocupado, mdio_oe, mdio_out}), 32'({2'b01, stream[k]}));
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check("reset_async",
              32'({mdc, mdio_out, mdio_oe, ocupado, listo, error, dato_leido}), 32'd0);
        check("reset_idle", 32'(estado_dbg), 32'b0001);
        void'(exp_q.pop_back());
        model_dato = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (mid && k == 20) begin
        iniciar = 1'b1;
        transaccion = ~fr;
      end
      if (mid && k == 21) iniciar = 1'b0;
      @(negedge clk);
    end
    check("fin", 32'({listo, ocupado, mdio_oe, mdio_out}), 32'b1000);
    check("dato_leido", 32'(dato_leido), 32'(exp_q.pop_front()));
    if (rd) begin
      check("tgt_cnt", 32'(tgt_cnt), 32'd16);
      check("tgt_regad", 32'(tgt_bits[6:2]), 32'(fr[22:18]));
    end else begin
      check("tgt_cnt", 32'(tgt_cnt), 32'd32);
      check("tgt_trama", tgt_bits, fr);
    end
    @(negedge clk);
    check("listo_ancho", 32'(listo), 32'd0);
    if (mid) begin
      repeat (6) begin
        @(negedge clk);
        check("sin_segundo_listo", 32'({listo, ocupado, mdio_oe}), 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [31:0] frame;
    logic [15:0] reply;
    bit          mid;
    bit          exp_err;
    logic [15:0] exp_dato;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] fr;
    logic [15:0] rp;
    bit          er;
    int          w;
    vecs[0] = '{32'h50A01234, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{32'h608E0000, 16'hA5C3, 1'b0, 1'b0, 16'hA5C3};
    vecs[2] = '{32'h40000000, 16'h0000, 1'b0, 1'b1, 16'hA5C3};
    vecs[3] = '{32'h70000000, 16'h0000, 1'b0, 1'b1, 16'hA5C3};
    vecs[4] = '{32'h5FFFAAAA, 16'h0000, 1'b1, 1'b0, 16'hA5C3};
    vecs[5] = '{32'h6ABE0000, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F};

    reset = 1'b1;
    iniciar = 1'b0;
    transaccion = '0;
    iniciar_p = 1'b0;
    trans_p = '0;
    mdio_in_p = 1'b0;
    tgt_reply = '0;
    #3;
    check("reset_salidas",
          32'({mdc, mdio_out, mdio_oe, ocupado, listo, error, dato_leido}), 32'd0);
    check("reset_estado", 32'(estado_dbg), 32'b0001);
    check("reset_pre", 32'({mdc_p, out_p, oe_p, ocu_p, listo_p, err_p, dato_p}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mdc_1", 32'(mdc), 32'd1);
    @(negedge clk);
    check("mdc_2", 32'(mdc), 32'd0);
    @(negedge clk);
    check("mdc_3", 32'(mdc), 32'd1);

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].frame, vecs[i].reply, vecs[i].mid, vecs[i].exp_err, vecs[i].exp_dato, -1);
    model_dato = vecs[5].exp_dato;

    for (int i = 0; i < 8; i++) begin
      fr = $urandom;
      fr[31:30] = 2'b01;
      rp = 16'($urandom_range(0, 16'hFFFF));
      er = (fr[29] == fr[28]);
      if (fr[29:28] == 2'b10) model_dato = rp;
      run_txn(fr, rp, 1'($urandom_range(0, 1)), er, model_dato, -1);
    end

    // Read aborted by reset during the receive phase, then a clean read.
    run_txn(32'h60C60000, 16'h1357, 1'b0, 1'b0, 16'h1357, 45);
    run_txn(32'h40000000, 16'h0000, 1'b0, 1'b1, model_dato, -1);
    run_txn(32'h61420000, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, -1);

    // 32-slot preamble before a write.
    fr = 32'h50A01234;
    @(negedge clk);
    trans_p = fr;
    iniciar_p = 1'b1;
    @(negedge clk);
    iniciar_p = 1'b0;
    trans_p = '0;
    check("pre_aceptar", 32'(ocu_p), 32'd1);
    w = 0;
    while (!oe_p && w < 4) begin
      @(negedge clk);
      w++;
    end
    check("pre_latencia", 32'(w >= 1 && w <= 2), 32'd1);
    for (int k = 0; k < 128; k++) begin
      check("pre_linea", 32'({listo_p, oe_p, out_p}),
            32'({1'b0, (k < 64) ? 2'b11 : {1'b1, fr[31 - (k - 64) / 2]}}));
      @(negedge clk);
    end
    check("pre_fin", 32'({listo_p, ocu_p, oe_p}), 32'b100);
    @(negedge clk);
    check("pre_listo_ancho", 32'(listo_p), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
